sobel_threshold_ctrl: RTL

SOBEL_THRESHOLD_CTRL -- requirements
Module: sobel_threshold_ctrl

---
 rtl/sobel_pkg.sv | 34 +++
 rtl/key_repeat_gen.sv | 93 +++++++++
 rtl/sobel_threshold_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared key codes, repeat FSM states and threshold helper for the
// Sobel threshold controller.
package sobel_pkg;

  localparam logic [3:0] KEY_DEC = 4'b0001;
  localparam logic [3:0] KEY_INC = 4'b0010;
  localparam logic [3:0] KEY_DEF = 4'b0100;
  localparam logic [3:0] KEY_BYP = 4'b1000;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_t;

  // th_min + grade*th_step computed in 64 bits, clamped to the
  // largest value representable in th_w bits (no wrap).
  function automatic logic [31:0] th_calc(
    input logic [31:0] grade,
    input logic [31:0] th_min,
    input logic [31:0] th_step,
    input int unsigned th_w
  );
    logic [63:0] sum;
    logic [63:0] top;
    sum = {32'd0, th_min} + ({32'd0, grade} * {32'd0, th_step});
    top = (64'd1 << th_w) - 64'd1;
    if (sum > top) begin
      return top[31:0];
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/key_repeat_gen.sv
// Held-key auto-repeat: after RPT_DLY held cycles emits one step, then
// one step every RPT_PER cycles while key_hold stays high.
// Ports: clk, rst (async, active high), key_flag/key_value (press
// pulse + one-hot code), key_hold (level); step (1-cycle pulse),
// step_inc (1 = increment, 0 = decrement).
module key_repeat_gen
  import sobel_pkg::*;
#(
  parameter int RPT_DLY = 50_000_000,
  parameter int RPT_PER = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_flag,
  input  logic [3:0] key_value,
  input  logic       key_hold,
  output logic       step,
  output logic       step_inc
);

  localparam int CNT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DLY_END = CNT_W'(RPT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_END = CNT_W'(RPT_PER - 1);

  rpt_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inc_q, inc_d;
  logic             is_step_key;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RPT_IDLE;
      cnt_q   <= '0;
      inc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inc_q   <= inc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    inc_d       = inc_q;
    step        = 1'b0;
    is_step_key = (key_value == KEY_INC) ||
                  (key_value == KEY_DEC);
    // A fresh press always wins: it restarts the delay or cancels.
    if (key_flag) begin
      cnt_d = '0;
      if (is_step_key) begin
        state_d = RPT_DELAY;
        inc_d   = (key_value == KEY_INC);
      end else begin
        state_d = RPT_IDLE;
      end
    end else if (!key_hold) begin
      state_d = RPT_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        RPT_IDLE: begin
        end
        RPT_DELAY: begin
          if (cnt_q == DLY_END) begin
            step    = 1'b1;
            state_d = RPT_REPEAT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RPT_REPEAT: begin
          if (cnt_q == PER_END) begin
            step  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = RPT_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign step_inc = inc_q;

endmodule

// File: rtl/sobel_threshold_ctrl.sv
// Key-driven Sobel edge threshold/bypass control, applied at frame
// boundaries. Ports: clk, rst (async, active high), key_flag,
// key_value, key_hold, frame_sync in; sobel_grade, sobel_threshold,
// sobel_bypass, th_update out. Define SOBEL_AUTO_REPEAT_EN to build
// the held-key auto-repeat; otherwise key_hold is ignored.
module sobel_threshold_ctrl
  import sobel_pkg::*;
#(
  parameter int GRADE_W   = 4,
  parameter int TH_W      = 8,
  parameter int TH_MIN    = 20,
  parameter int TH_STEP   = 5,
  parameter int DEF_GRADE = 8,
  parameter int RPT_DLY   = 50_000_000,
  parameter int RPT_PER   = 10_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_flag,
  input  logic [3:0]         key_value,
  input  logic               key_hold,
  input  logic               frame_sync,
  output logic [GRADE_W-1:0] sobel_grade,
  output logic [TH_W-1:0]    sobel_threshold,
  output logic               sobel_bypass,
  output logic               th_update
);

  localparam logic [GRADE_W-1:0] GRADE_MAX = '1;
  localparam logic [GRADE_W-1:0] GRADE_DEF = GRADE_W'(DEF_GRADE);
  localparam logic [TH_W-1:0]    TH_RST    =
    TH_W'(th_calc(32'(DEF_GRADE), TH_MIN, TH_STEP, TH_W));

  logic [GRADE_W-1:0] grade_q, grade_d;
  logic [TH_W-1:0]    thr_q, thr_d;
  logic               byp_pend_q, byp_pend_d;
  logic               byp_q, byp_d;
  logic               upd_q, upd_d;
  logic [TH_W-1:0]    pend_th;
  logic               rpt_step;
  logic               rpt_inc;

`ifdef SOBEL_AUTO_REPEAT_EN
  key_repeat_gen #(
    .RPT_DLY (RPT_DLY),
    .RPT_PER (RPT_PER)
  ) u_key_repeat_gen (
    .clk       (clk),
    .rst       (rst),
    .key_flag  (key_flag),
    .key_value (key_value),
    .key_hold  (key_hold),
    .step      (rpt_step),
    .step_inc  (rpt_inc)
  );
`else
  localparam int unused_rpt = RPT_DLY + RPT_PER;
  logic unused_key_hold;
  assign unused_key_hold = key_hold;
  assign rpt_step        = 1'b0;
  assign rpt_inc         = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grade_q    <= GRADE_DEF;
      thr_q      <= TH_RST;
      byp_pend_q <= 1'b0;
      byp_q      <= 1'b0;
      upd_q      <= 1'b0;
    end else begin
      grade_q    <= grade_d;
      thr_q      <= thr_d;
      byp_pend_q <= byp_pend_d;
      byp_q      <= byp_d;
      upd_q      <= upd_d;
    end
  end

  always_comb begin
    grade_d    = grade_q;
    thr_d      = thr_q;
    byp_pend_d = byp_pend_q;
    byp_d      = byp_q;
    upd_d      = 1'b0;
    // Pending value tracks the current grade; a key in the same
    // cycle as frame_sync only reaches the next frame.
    pend_th = TH_W'(th_calc(32'(grade_q), TH_MIN, TH_STEP, TH_W));

    if (frame_sync) begin
      thr_d = pend_th;
      upd_d = (pend_th != thr_q);
      byp_d = byp_pend_q;
    end

    if (key_flag) begin
      unique case (1'b1)
        (key_value == KEY_DEC): begin
          if (grade_q != '0) grade_d = grade_q - GRADE_W'(1);
        end
        (key_value == KEY_INC): begin
          if (grade_q != GRADE_MAX) grade_d = grade_q + GRADE_W'(1);
        end
        (key_value == KEY_DEF): begin
          grade_d = GRADE_DEF;
        end
        (key_value == KEY_BYP): begin
          byp_pend_d = ~byp_pend_q;
        end
        default: begin
        end
      endcase
    end else if (rpt_step) begin
      if (rpt_inc) begin
        if (grade_q != GRADE_MAX) grade_d = grade_q + GRADE_W'(1);
      end else begin
        if (grade_q != '0) grade_d = grade_q - GRADE_W'(1);
      end
    end
  end

  assign sobel_grade     = grade_q;
  assign sobel_threshold = thr_q;
  assign sobel_bypass    = byp_q;
  assign th_update       = upd_q;

endmodule
